// File: rtl/line_kcpe_conv2d_ctrl_pkg.sv
// Shared types for the line-based KCPE conv2d sequencer: FSM states,
// buffer read latency and the read-strobe bundle that rides the valid pipeline.
package line_kcpe_conv2d_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int unsigned BUF_RD_LAT = 1;

   typedef struct packed {
      logic weight;
      logic data;
      logic zero;
   } rd_vld_t;

endpackage

// File: rtl/line_kcpe_conv2d_ctrl_if.sv
// Buffer and engine side bus of the conv2d sequencer; master is the controller.
interface line_kcpe_conv2d_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_KERNEL = 4
) ();
   logic                  o_weight_rd;
   logic [ADDR_WIDTH-1:0] o_weight_addr;
   logic                  o_data_rd;
   logic [ADDR_WIDTH-1:0] o_data_addr;
   logic                  o_psum_rd;
   logic [ADDR_WIDTH-1:0] o_psum_rd_addr;
   logic                  o_eng_weight_val;
   logic                  o_eng_data_val;
   logic                  o_eng_psum_val;
   logic                  o_psum_zero;
   logic [NUM_KERNEL-1:0] i_eng_psum_val;
   logic                  o_psum_wr;
   logic [ADDR_WIDTH-1:0] o_psum_wr_addr;

   modport master (
      output o_weight_rd, o_weight_addr, o_data_rd, o_data_addr,
      output o_psum_rd, o_psum_rd_addr, o_eng_weight_val, o_eng_data_val,
      output o_eng_psum_val, o_psum_zero, o_psum_wr, o_psum_wr_addr,
      input  i_eng_psum_val
   );

   modport slave (
      input  o_weight_rd, o_weight_addr, o_data_rd, o_data_addr,
      input  o_psum_rd, o_psum_rd_addr, o_eng_weight_val, o_eng_data_val,
      input  o_eng_psum_val, o_psum_zero, o_psum_wr, o_psum_wr_addr,
      output i_eng_psum_val
   );
endinterface

// File: rtl/line_kcpe_conv2d_ctrl_addr_gen.sv
// Channel-group / kernel-row / position counters and the buffer address
// arithmetic derived from them.
module line_kcpe_addr_gen
   import line_kcpe_conv2d_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int CNT_WIDTH   = 8,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  step,
   input  logic [CNT_WIDTH-1:0]  num_pos,
   input  logic [CNT_WIDTH-1:0]  num_cgrp,
   input  logic [ADDR_WIDTH-1:0] data_base,
   input  logic [ADDR_WIDTH-1:0] weight_base,
   input  logic [ADDR_WIDTH-1:0] psum_base,
   output logic [ADDR_WIDTH-1:0] weight_addr,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [ADDR_WIDTH-1:0] psum_addr,
   output logic                  first_pass,
   output logic                  first_pos,
   output logic                  last_pos,
   output logic                  last_row,
   output logic                  last_grp
);
   localparam int R_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

   logic [CNT_WIDTH-1:0]  g;
   logic [CNT_WIDTH-1:0]  p;
   logic [R_W-1:0]        r;
   logic [ADDR_WIDTH-1:0] row;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         g <= '0;
         r <= '0;
         p <= '0;
      end else if (step) begin
         if (last_pos) begin
            p <= '0;
            if (last_row) begin
               r <= '0;
               g <= g + CNT_WIDTH'(1);
            end else begin
               r <= r + R_W'(1);
            end
         end else begin
            p <= p + CNT_WIDTH'(1);
         end
      end
   end

   assign last_pos   = (p == num_pos - CNT_WIDTH'(1));
   assign last_row   = (r == R_W'(KERNEL_SIZE - 1));
   assign last_grp   = (g == num_cgrp - CNT_WIDTH'(1));
   assign first_pass = (g == '0) && (r == '0);
   assign first_pos  = (p == '0);

   // Row index of the current pass in the weight/data layout.
   assign row         = ADDR_WIDTH'(g) * ADDR_WIDTH'(KERNEL_SIZE) + ADDR_WIDTH'(r);
   assign weight_addr = weight_base + row;
   assign data_addr   = data_base + row * ADDR_WIDTH'(num_pos) + ADDR_WIDTH'(p);
   assign psum_addr   = psum_base + ADDR_WIDTH'(p);

endmodule

// File: rtl/line_kcpe_conv2d_ctrl.sv
// Sequencer for one line of a 3x3x4 KCPE conv2d engine: issue, valid pipeline,
// psum writeback. Optional error counters under LINE_KCPE_CTRL_ERR_MON_EN.
module line_kcpe_conv2d_ctrl
   import line_kcpe_conv2d_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH      = 16,
   parameter int CNT_WIDTH       = 8,
   parameter int KERNEL_SIZE     = 3,
   parameter int MAX_OUTSTANDING = 8,
`ifdef LINE_KCPE_CTRL_ERR_MON_EN
   parameter int REG_WIDTH       = 32,
`endif
   parameter int NUM_KERNEL      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [CNT_WIDTH-1:0]  i_num_pos,
   input  logic [CNT_WIDTH-1:0]  i_num_cgrp,
   input  logic [ADDR_WIDTH-1:0] i_data_base,
   input  logic [ADDR_WIDTH-1:0] i_weight_base,
   input  logic [ADDR_WIDTH-1:0] i_psum_base,
   input  logic                  i_stall,
   output logic                  o_busy,
   output logic                  o_done,
`ifdef LINE_KCPE_CTRL_ERR_MON_EN
   output logic [REG_WIDTH-1:0]  o_err_psum_val,
   output logic [REG_WIDTH-1:0]  o_err_ovf,
`endif
   line_kcpe_conv2d_ctrl_if.master bus
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   state_t                state, state_nx;
   logic [CNT_WIDTH-1:0]  num_pos_q, num_cgrp_q, wp;
   logic [ADDR_WIDTH-1:0] data_base_q, weight_base_q, psum_base_q;
   logic [OUT_W-1:0]      outstanding;
   logic [NUM_KERNEL-1:0] eng_psum_val;
   logic                  cfg_zero, clr, issue, wb, out_dec;
   logic                  first_pass, first_pos, last_pos, last_row, last_grp;
   logic [ADDR_WIDTH-1:0] w_addr, d_addr, pr_addr;
   rd_vld_t               rd_now;
   rd_vld_t               rd_pipe [BUF_RD_LAT];

   line_kcpe_addr_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH),
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_addr_gen (
      .clk, .rst, .clr, .step(issue),
      .num_pos(num_pos_q), .num_cgrp(num_cgrp_q),
      .data_base(data_base_q), .weight_base(weight_base_q), .psum_base(psum_base_q),
      .weight_addr(w_addr), .data_addr(d_addr), .psum_addr(pr_addr),
      .first_pass, .first_pos, .last_pos, .last_row, .last_grp
   );

   assign cfg_zero     = (i_num_pos == '0) || (i_num_cgrp == '0);
   assign eng_psum_val = bus.i_eng_psum_val;

   // A non-first pass starts only once every psum of the previous pass is back,
   // which keeps each psum read behind the write of the same position.
   always_comb begin
      state_nx = state;
      clr      = 1'b0;
      issue    = 1'b0;
      case (state)
         S_IDLE: if (i_start) begin
            clr      = 1'b1;
            state_nx = cfg_zero ? S_DONE : S_LOAD_W;
         end
         S_LOAD_W: state_nx = S_RUN;
         S_RUN: begin
            issue = !i_stall && (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                    (first_pass || !first_pos || (outstanding == '0));
            if (issue && last_pos)
               state_nx = (last_row && last_grp) ? S_DRAIN : S_LOAD_W;
         end
         S_DRAIN: if (outstanding == '0) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign wb      = (state != S_IDLE) && (eng_psum_val == '1);
   assign out_dec = wb && (outstanding != '0);
   assign rd_now  = '{weight: (state == S_LOAD_W), data: issue, zero: issue && first_pass};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         num_pos_q     <= '0;
         num_cgrp_q    <= '0;
         data_base_q   <= '0;
         weight_base_q <= '0;
         psum_base_q   <= '0;
         outstanding   <= '0;
         wp            <= '0;
         for (int unsigned i = 0; i < BUF_RD_LAT; i++) rd_pipe[i] <= '0;
      end else begin
         state <= state_nx;
         if (clr) begin
            num_pos_q     <= i_num_pos;
            num_cgrp_q    <= i_num_cgrp;
            data_base_q   <= i_data_base;
            weight_base_q <= i_weight_base;
            psum_base_q   <= i_psum_base;
         end
         case ({issue, out_dec})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (clr)
            wp <= '0;
         else if (wb)
            wp <= (wp == num_pos_q - CNT_WIDTH'(1)) ? '0 : wp + CNT_WIDTH'(1);
         rd_pipe[0] <= rd_now;
         for (int unsigned i = 1; i < BUF_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

`ifdef LINE_KCPE_CTRL_ERR_MON_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_err_psum_val <= '0;
         o_err_ovf      <= '0;
      end else begin
         if ((eng_psum_val != '0) && (eng_psum_val != '1) && (o_err_psum_val != '1))
            o_err_psum_val <= o_err_psum_val + REG_WIDTH'(1);
         if (wb && (outstanding == '0) && (o_err_ovf != '1))
            o_err_ovf <= o_err_ovf + REG_WIDTH'(1);
      end
   end
`endif

   assign bus.o_weight_rd      = (state == S_LOAD_W);
   assign bus.o_weight_addr    = w_addr;
   assign bus.o_data_rd        = issue;
   assign bus.o_data_addr      = d_addr;
   assign bus.o_psum_rd        = issue && !first_pass;
   assign bus.o_psum_rd_addr   = pr_addr;
   assign bus.o_eng_weight_val = rd_pipe[BUF_RD_LAT-1].weight;
   assign bus.o_eng_data_val   = rd_pipe[BUF_RD_LAT-1].data;
   assign bus.o_eng_psum_val   = rd_pipe[BUF_RD_LAT-1].data;
   assign bus.o_psum_zero      = rd_pipe[BUF_RD_LAT-1].zero;
   assign bus.o_psum_wr        = wb;
   assign bus.o_psum_wr_addr   = psum_base_q + ADDR_WIDTH'(wp);
   assign o_busy               = (state != S_IDLE);
   assign o_done               = (state == S_DONE);

endmodule

// File: tb/tb_line_kcpe_conv2d_ctrl.sv
// Scoreboard bench for line_kcpe_conv2d_ctrl with a latency-programmable engine
// model; also covers the LINE_KCPE_CTRL_ERR_MON_EN counters when that macro is set.
module tb_line_kcpe_conv2d_ctrl;
   localparam int KS = 3;
   localparam int MO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_stall = 1'b0;
   logic [7:0]  i_num_pos = '0, i_num_cgrp = '0;
   logic [15:0] i_data_base = '0, i_weight_base = '0, i_psum_base = '0;
   logic        o_busy, o_done;
`ifdef LINE_KCPE_CTRL_ERR_MON_EN
   logic [31:0] o_err_psum_val, o_err_ovf;
`endif

   line_kcpe_conv2d_ctrl_if #(.ADDR_WIDTH(16), .NUM_KERNEL(4)) bus ();

   line_kcpe_conv2d_ctrl dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_num_pos(i_num_pos), .i_num_cgrp(i_num_cgrp),
      .i_data_base(i_data_base), .i_weight_base(i_weight_base), .i_psum_base(i_psum_base),
      .i_stall(i_stall), .o_busy(o_busy), .o_done(o_done),
`ifdef LINE_KCPE_CTRL_ERR_MON_EN
      .o_err_psum_val(o_err_psum_val), .o_err_ovf(o_err_ovf),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        psum_rd;
      logic [15:0] paddr;
      int          pass;
      int          pos;
   } dexp_t;

   logic [15:0]  exp_w[$];
   dexp_t        exp_d[$];
   logic         exp_z[$];
   logic [15:0]  exp_wr[$];
   int unsigned  due[$];

   int errors = 0, checks = 0;
   int unsigned cyc = 0;
   int eng_lat = 3, cur_p = 1;
   int wr_cnt = 0, out_m = 0, out_peak = 0, resume_ev = 0, busy_cnt = 0, done_cnt = 0;
   int force_stall = 0;
   bit rand_stall = 0, prev_full_wr = 0;
   logic [3:0] inject = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=strobe required=none", name);
   endtask

   // Engine and stall drivers: inputs change 1 time unit after the rising edge.
   initial begin
      bus.i_eng_psum_val = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (inject != '0) begin
            bus.i_eng_psum_val = inject;
            inject = '0;
         end else if (due.size() > 0 && due[0] <= cyc) begin
            bus.i_eng_psum_val = '1;
            void'(due.pop_front());
         end else begin
            bus.i_eng_psum_val = '0;
         end
         if (force_stall > 0) begin
            i_stall = 1'b1;
            force_stall--;
         end else begin
            i_stall = rand_stall ? ($urandom_range(3, 0) == 0) : 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a strobe.
   initial begin
      dexp_t e;
      bit full_at_start;
      forever begin
         @(negedge clk);
         if (bus.o_eng_data_val) due.push_back(cyc + eng_lat);
         if (rst) begin
            prev_full_wr = 0;
         end else begin
            if (i_stall) check("stall_no_issue", bus.o_data_rd, 0);
            if (bus.o_weight_rd) begin
               if (exp_w.size() == 0) unexpected("weight_rd");
               else check("weight_addr", bus.o_weight_addr, exp_w.pop_front());
            end
            if (bus.o_data_rd) begin
               if (exp_d.size() == 0) unexpected("data_rd");
               else begin
                  e = exp_d.pop_front();
                  check("data_addr", bus.o_data_addr, e.addr);
                  check("psum_rd", bus.o_psum_rd, e.psum_rd);
                  if (e.psum_rd) begin
                     check("psum_rd_addr", bus.o_psum_rd_addr, e.paddr);
                     check("hazard_order", wr_cnt >= (e.pass - 1) * cur_p + e.pos + 1, 1);
                  end
               end
            end else begin
               check("psum_rd_idle", bus.o_psum_rd, 0);
            end
            if (bus.o_eng_data_val) begin
               check("eng_psum_val", bus.o_eng_psum_val, 1);
               if (exp_z.size() == 0) unexpected("eng_data_val");
               else check("psum_zero", bus.o_psum_zero, exp_z.pop_front());
            end
            full_at_start = (out_m == MO);
            if (bus.o_psum_wr) begin
               if (exp_wr.size() == 0) unexpected("psum_wr");
               else check("psum_wr_addr", bus.o_psum_wr_addr, exp_wr.pop_front());
               wr_cnt++;
               out_m--;
            end
            if (bus.o_data_rd) begin
               if (prev_full_wr) resume_ev++;
               out_m++;
               if (out_m > out_peak) out_peak = out_m;
               check("outstanding_bound", out_m <= MO, 1);
            end
            prev_full_wr = full_at_start && bus.o_psum_wr;
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
         end
      end
   end

   task automatic check_all_zero(input string name);
      check({name, "_strobes"},
            {bus.o_weight_rd, bus.o_data_rd, bus.o_psum_rd, bus.o_eng_weight_val,
             bus.o_eng_data_val, bus.o_eng_psum_val, bus.o_psum_zero, bus.o_psum_wr,
             o_busy, o_done}, 0);
      check({name, "_addrs"},
            {bus.o_weight_addr, bus.o_data_addr, bus.o_psum_rd_addr, bus.o_psum_wr_addr}, 0);
   endtask

   task automatic clear_stats(input int p);
      cur_p = p; wr_cnt = 0; out_m = 0; out_peak = 0; resume_ev = 0;
      busy_cnt = 0; done_cnt = 0;
   endtask

   // Reference: passes walk (g, r); each pass reads every position once.
   task automatic push_expect(input int p_n, input int g_n, input logic [15:0] db,
                              input logic [15:0] wb, input logic [15:0] pb);
      int pass;
      for (int g = 0; g < g_n; g++)
         for (int r = 0; r < KS; r++) begin
            pass = g * KS + r;
            exp_w.push_back(16'(wb + pass));
            for (int p = 0; p < p_n; p++) begin
               exp_d.push_back('{16'(db + pass * p_n + p), pass != 0, 16'(pb + p), pass, p});
               exp_z.push_back(pass == 0);
               exp_wr.push_back(16'(pb + p));
            end
         end
   endtask

   task automatic pulse_start(input int p_n, input int g_n, input logic [15:0] db,
                              input logic [15:0] wb, input logic [15:0] pb);
      @(posedge clk); #1;
      i_num_pos = 8'(p_n); i_num_cgrp = 8'(g_n);
      i_data_base = db; i_weight_base = wb; i_psum_base = pb;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic run_line(input int p_n, input int g_n, input logic [15:0] db,
                           input logic [15:0] wb, input logic [15:0] pb,
                           input int lat, input bit rstall, input bit stall_p2);
      int t;
      bit found;
      clear_stats(p_n);
      eng_lat = lat;
      push_expect(p_n, g_n, db, wb, pb);
      pulse_start(p_n, g_n, db, wb, pb);
      rand_stall = rstall;
      if (stall_p2) begin
         found = 0;
         for (t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (bus.o_data_rd && bus.o_data_addr == 16'(db + 1)) found = 1;
         end
         check("stall_trigger_seen", found, 1);
         force_stall = 5;
      end
      for (t = 0; t < 20000 && done_cnt == 0; t++) @(negedge clk);
      rand_stall = 0;
      repeat (3) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("write_count", wr_cnt, p_n * g_n * KS);
      check("left_data", exp_d.size(), 0);
      check("left_weight", exp_w.size(), 0);
      check("left_writes", exp_wr.size(), 0);
      check("busy_after_done", o_busy, 0);
      exp_w.delete(); exp_d.delete(); exp_z.delete(); exp_wr.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_state");
`ifdef LINE_KCPE_CTRL_ERR_MON_EN
      check("err_reset", {o_err_psum_val, o_err_ovf}, 0);
`endif

      run_line(4, 1, 16'h0, 16'h0, 16'h0, 3, 0, 0);

      clear_stats(1);
      pulse_start(0, 1, 16'h10, 16'h20, 16'h30);
      repeat (6) @(negedge clk);
      check("zero_pos_done", done_cnt, 1);
      check("zero_pos_busy", busy_cnt, 1);

      run_line(16, 2, 16'h0, 16'h0, 16'h0, 12, 0, 0);
      check("outstanding_peak", out_peak, MO);
      check("resume_after_wb", resume_ev > 0, 1);

      run_line(8, 1, 16'h0100, 16'h0020, 16'h0300, 4, 0, 1);

      // Reset three issues into RUN; late engine results must not write.
      begin
         bit found;
         clear_stats(8);
         eng_lat = 6;
         push_expect(8, 1, 16'h40, 16'h0, 16'h80);
         pulse_start(8, 1, 16'h40, 16'h0, 16'h80);
         found = 0;
         for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (bus.o_data_rd && bus.o_data_addr == 16'h42) found = 1;
         end
         check("abort_trigger_seen", found, 1);
         @(posedge clk); #1;
         rst = 1'b1;
         exp_w.delete(); exp_d.delete(); exp_z.delete(); exp_wr.delete();
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         check_all_zero("abort_reset");
         repeat (25) @(negedge clk);
         check("abort_idle", o_busy, 0);
      end
      run_line(5, 1, 16'h0, 16'h7, 16'h9, 5, 0, 0);

      for (int it = 0; it < 4; it++)
         run_line(int'($urandom_range(12, 1)), int'($urandom_range(3, 1)),
                  16'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(12, 1)), 1, 0);

`ifdef LINE_KCPE_CTRL_ERR_MON_EN
      @(negedge clk);
      inject = 4'b0101;
      repeat (3) @(negedge clk);
      inject = 4'b0101;
      repeat (3) @(negedge clk);
      check("err_psum_val", o_err_psum_val, 2);
      check("err_ovf", o_err_ovf, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_kcpe_conv2d_ctrl.md
Name: line_kcpe_conv2d_ctrl

Overview:
Sequencer for one line-based kernel-channel-PE conv2d engine (3 KCPE x 3 channels x 4 kernels). Walks channel groups, kernel rows and output positions for one output line. Issues weight/data buffer reads and engine valid strobes, selects zero versus stored psum, and writes completed psums back to the psum buffer. Sits between the tile configuration registers and the engine plus its data, weight and psum buffers.

Parameters:
ADDR_WIDTH, 16, buffer address width (data, weight, psum)
CNT_WIDTH, 8, width of position and channel-group counts
KERNEL_SIZE, 3, kernel rows per channel group (one engine pass per row)
MAX_OUTSTANDING, 8, max issued-but-not-written-back positions
REG_WIDTH, 32, status/error register width
NUM_KERNEL, 4, kernels per engine (width of engine psum valid)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  start pulse; sampled only in IDLE
i_num_pos  in  CNT_WIDTH  output positions per line
i_num_cgrp  in  CNT_WIDTH  channel groups (3 channels each)
i_data_base  in  ADDR_WIDTH  data buffer base address
i_weight_base  in  ADDR_WIDTH  weight buffer base address
i_psum_base  in  ADDR_WIDTH  psum buffer base address
i_stall  in  1  downstream back-pressure; blocks new issue
o_weight_rd  out  1  weight buffer read strobe
o_weight_addr  out  ADDR_WIDTH  weight read address
o_data_rd  out  1  data buffer read strobe
o_data_addr  out  ADDR_WIDTH  data read address
o_psum_rd  out  1  psum buffer read strobe
o_psum_rd_addr  out  ADDR_WIDTH  psum read address
o_eng_weight_val  out  1  engine i_weight_val
o_eng_data_val  out  1  engine i_data_val
o_eng_psum_val  out  1  engine i_psum_val
o_psum_zero  out  1  engine psum input mux selects zero
i_eng_psum_val  in  NUM_KERNEL  engine o_psum_val
o_psum_wr  out  1  psum buffer write strobe
o_psum_wr_addr  out  ADDR_WIDTH  psum write address
o_busy  out  1  high outside IDLE
o_done  out  1  one-cycle pulse at line completion

Behaviour:
- Reset: state IDLE; all counters 0; every output 0. Reset mid-operation aborts immediately; in-flight engine results arriving later are ignored (no o_psum_wr) until the next i_start.
- States: IDLE -> LOAD_W -> RUN -> (LOAD_W | DRAIN) -> DONE -> IDLE.
- IDLE: on i_start, latch all i_* config. If i_num_pos==0 or i_num_cgrp==0, go to DONE; no reads are issued. Otherwise go to LOAD_W with g=0, r=0.
- LOAD_W: one cycle. o_weight_rd=1, o_weight_addr = weight_base + g*KERNEL_SIZE + r. Then RUN with p=0.
- RUN: issue when !i_stall and outstanding<MAX_OUTSTANDING. An issue sets o_data_rd=1 with o_data_addr = data_base + (g*KERNEL_SIZE + r)*num_pos + p.
  - Same issue, when the pass is not first (g!=0 or r!=0): o_psum_rd=1 with o_psum_rd_addr = psum_base + p.
  - First pass (g==0 and r==0): no psum read; o_psum_zero=1.
- Last position: after the issue with p==num_pos-1, r increments. On wrap (r==KERNEL_SIZE-1) r returns to 0 and g increments.
  - If g was num_cgrp-1, go to DRAIN; otherwise go to LOAD_W.
- Buffer read latency is fixed at 1 cycle. o_eng_weight_val, o_eng_data_val, o_eng_psum_val and o_psum_zero are the corresponding strobe/flag delayed one cycle.
- o_eng_psum_val is asserted with every data valid; zero or stored data is chosen by o_psum_zero.
- Writeback: when i_eng_psum_val == all ones, o_psum_wr=1 the same cycle (combinational from the registered write pointer). o_psum_wr_addr = psum_base + wp; wp wraps to 0 after num_pos-1.
  - An all-zero i_eng_psum_val is ignored. A partial value is a protocol error and is not written.
- Outstanding counter: +1 per data issue, -1 per writeback. Simultaneous issue and writeback leave it unchanged. It never exceeds MAX_OUTSTANDING.
- Hazard rule: the next pass's psum read for position p must follow the write of p. Issue of position p in a non-first pass is blocked while outstanding != 0 and wp <= p within the previous pass. Implement this as: the first issue of each non-first pass waits for outstanding==0.
- DRAIN: waits for outstanding==0, then goes to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy is low only in IDLE.
- i_start is ignored outside IDLE. i_stall in LOAD_W has no effect.

Optional Feature:
LINE_KCPE_CTRL_ERR_MON_EN
- Defined: adds outputs o_err_psum_val (REG_WIDTH) and o_err_ovf (REG_WIDTH), both saturating and cleared by rst.
  - o_err_psum_val counts cycles with a partial i_eng_psum_val.
  - o_err_ovf counts writebacks arriving while outstanding==0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE/LOAD_W/RUN/DRAIN/DONE) and the 1-cycle buffer read latency constant.
- One natural sub-module: line_kcpe_addr_gen. It holds the g/r/p counters and address arithmetic and outputs wrap flags. The FSM, valid pipeline and writeback stay in the top module.

Test Plan:
- num_pos=4, num_cgrp=1, all bases 0, engine model latency 3, no stall:
  - 3 weight reads at 0,1,2; 12 data reads at addresses 0..11.
  - o_psum_zero set only on the first 4 engine valids.
  - 12 writes with addresses 0,1,2,3 repeating; o_done once; total 18 + drain cycles.
- num_pos=0 with i_start -> no strobes; o_done pulses 2 cycles after start; o_busy high for exactly those cycles.
- num_pos=16, num_cgrp=2, engine latency 12 -> outstanding peaks at 8 and never exceeds it; issue resumes the cycle after a writeback; 96 writes total.
- i_stall held 5 cycles mid-RUN at p=2 -> no o_data_rd during the stall; addresses resume at p=2; final write count unchanged.
- rst asserted 3 cycles into RUN -> all outputs 0 next cycle; late engine valids produce no o_psum_wr; a new i_start runs cleanly from p=0.
- ERR_MON_EN build: inject i_eng_psum_val=4'b0101 twice -> o_err_psum_val=2; no write for those cycles.
